// File: rtl/sndseq_pkg.sv
// Shared definitions for the pattern sequencer: FSM state encoding,
// pattern ROM field layout and voice count.
package sndseq_pkg;

    // Voices per pattern row; voice_sel is 2 bits, so this is fixed at 4.
    localparam int VOICES = 4;
    localparam logic [1:0] LAST_VOICE = 2'(VOICES - 1);

    // Pattern ROM byte layout.
    localparam int GATE_BIT = 7;
    localparam int TIE_BIT  = 6;
    localparam int NOTE_LSB = 0;
    localparam int NOTE_MSB = 5;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT    = 3'd1,
        S_FETCH   = 3'd2,
        S_LATCH   = 3'd3,
        S_WRITE   = 3'd4,
        S_RELEASE = 3'd5
    } state_t;

    // True while a pattern row is being fetched and written.
    function automatic logic is_row_state(input state_t s);
        return (s == S_FETCH) || (s == S_LATCH) || (s == S_WRITE);
    endfunction

endpackage

// File: rtl/tempo_divider.sv
// Step-tick generator: counts sample strobes up to max(tempo,1) and keeps a
// one-deep pending flag for a tick that lands while a row is still playing.
module tempo_divider #(
    parameter int TEMPO_W = 12
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               sample_ena,
    input  logic               enable,
    input  logic               clear,
    input  logic               row_active,
    input  logic               consume,
    input  logic [TEMPO_W-1:0] tempo,
    output logic               tick,
    output logic               pending
);
    logic [TEMPO_W-1:0] count_q;
    logic [TEMPO_W-1:0] tempo_q;
    logic [TEMPO_W-1:0] limit;
    logic               pending_q;

    // Effective step length: a tempo of zero behaves as one strobe per step.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latch).
        limit = tempo_q;
        if (tempo_q == '0) begin
            limit = TEMPO_W'(1);
        end
    end

    assign tick    = enable && sample_ena && (count_q == limit - TEMPO_W'(1));
    assign pending = pending_q;

    // Strobe counter; tempo is re-sampled whenever a new step starts counting.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            count_q <= '0;
            tempo_q <= '0;
        end else if (clear || tick) begin
            count_q <= '0;
            tempo_q <= tempo;
        end else if (enable && sample_ena) begin
            count_q <= count_q + TEMPO_W'(1);
        end
    end

    // Remembers a tick that arrived while a row was still being written.
    // When the row end consumes a pending tick in the same clock as a fresh
    // tick, the fresh one stays pending so no step is lost.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending_q <= 1'b0;
        end else if (clear) begin
            pending_q <= 1'b0;
        end else if (consume) begin
            pending_q <= pending_q && tick;
        end else if (tick && row_active) begin
            pending_q <= 1'b1;
        end
    end

endmodule

// File: rtl/pattern_sequencer.sv
// Tempo-driven note scheduler: on each step tick, reads one 4-voice row from
// the pattern ROM and writes note/gate updates to the sound generator voice
// registers through a single time-shared write port.
module pattern_sequencer
    import sndseq_pkg::*;
#(
    parameter int STEP_W  = 5,
    parameter int TEMPO_W = 12
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               sample_ena,
    input  logic               run,
    input  logic [TEMPO_W-1:0] tempo,
    output logic [STEP_W+1:0]  rom_addr,
    input  logic [7:0]         rom_data,
    output logic               voice_we,
    output logic [1:0]         voice_sel,
    output logic [5:0]         voice_note,
    output logic               voice_gate,
    output logic [STEP_W-1:0]  step_idx,
    output logic               step_pulse,
    output logic               busy
);
    state_t            state_q;
    state_t            state_d;
    logic [1:0]        voice_q;
    logic [1:0]        voice_d;
    logic [STEP_W-1:0] step_q;
    logic [STEP_W-1:0] step_d;
    logic [7:0]        data_q;

    logic count_clear;
    logic consume;
    logic tick;
    logic pending;
    logic row_active;
    logic count_enable;

    // Tempo keeps counting through the row so a slow row never stretches a step.
    assign row_active   = is_row_state(state_q);
    assign count_enable = row_active || (state_q == S_WAIT);

    tempo_divider #(
        .TEMPO_W (TEMPO_W)
    ) u_tempo_divider (
        .clock      (clock),
        .reset      (reset),
        .sample_ena (sample_ena),
        .enable     (count_enable),
        .clear      (count_clear),
        .row_active (row_active),
        .consume    (consume),
        .tempo      (tempo),
        .tick       (tick),
        .pending    (pending)
    );

    assign rom_addr = {step_q, voice_q};
    assign step_idx = step_q;

    // State, voice index and step index registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            voice_q <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            voice_q <= voice_d;
            step_q  <= step_d;
        end
    end

    // Capture the ROM byte one clock after its address was presented.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else if (state_q == S_LATCH) begin
            data_q <= rom_data;
        end
    end

    // Next-state logic and the shared voice write port.
    always_comb begin
        state_d     = state_q;
        voice_d     = voice_q;
        step_d      = step_q;
        count_clear = 1'b0;
        consume     = 1'b0;
        voice_we    = 1'b0;
        voice_sel   = '0;
        voice_note  = '0;
        voice_gate  = 1'b0;
        step_pulse  = 1'b0;
        busy        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d     = S_FETCH;
                    step_d      = '0;
                    voice_d     = '0;
                    count_clear = 1'b1;
                end
            end

            S_WAIT: begin
                if (!run) begin
                    state_d = S_RELEASE;
                    voice_d = '0;
                end else if (tick) begin
                    state_d = S_FETCH;
                    step_d  = step_q + STEP_W'(1);
                    voice_d = '0;
                end
            end

            S_FETCH: begin
                busy       = 1'b1;
                step_pulse = (voice_q == '0);
                state_d    = S_LATCH;
            end

            S_LATCH: begin
                busy    = 1'b1;
                state_d = S_WRITE;
            end

            S_WRITE: begin
                busy = 1'b1;
                // A tied note leaves the voice register untouched.
                if (!data_q[TIE_BIT]) begin
                    voice_we   = 1'b1;
                    voice_sel  = voice_q;
                    voice_note = data_q[NOTE_MSB:NOTE_LSB];
                    voice_gate = data_q[GATE_BIT];
                end
                if (voice_q != LAST_VOICE) begin
                    voice_d = voice_q + 2'd1;
                    state_d = S_FETCH;
                end else if (!run) begin
                    state_d = S_RELEASE;
                    voice_d = '0;
                end else if (pending || tick) begin
                    state_d = S_FETCH;
                    step_d  = step_q + STEP_W'(1);
                    voice_d = '0;
                    consume = 1'b1;
                end else begin
                    state_d = S_WAIT;
                end
            end

            S_RELEASE: begin
                busy      = 1'b1;
                voice_we  = 1'b1;
                voice_sel = voice_q;
                if (voice_q == LAST_VOICE) begin
                    state_d = S_IDLE;
                end else begin
                    voice_d = voice_q + 2'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer: row playback, tempo stepping and wrap,
// tied voices, tempo 0/1 with back-to-back ticks, stop/release and mid-row reset.
module tb_pattern_sequencer;
    localparam int STEP_W  = 5;
    localparam int TEMPO_W = 12;

    logic               clock = 1'b0;
    logic               reset;
    logic               sample_ena;
    logic               run;
    logic [TEMPO_W-1:0] tempo;
    logic [STEP_W+1:0]  rom_addr;
    logic [7:0]         rom_data = '0;
    logic               voice_we;
    logic [1:0]         voice_sel;
    logic [5:0]         voice_note;
    logic               voice_gate;
    logic [STEP_W-1:0]  step_idx;
    logic               step_pulse;
    logic               busy;

    // One observed write: {sel, note, gate}.
    typedef logic [8:0] wr_t;

    logic [7:0] rom_mem [0:127];
    wr_t        wr_q [$];
    int         pulse_cnt = 0;
    int         n_checks  = 0;
    int         n_errors  = 0;

    pattern_sequencer #(
        .STEP_W  (STEP_W),
        .TEMPO_W (TEMPO_W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .sample_ena (sample_ena),
        .run        (run),
        .tempo      (tempo),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .voice_we   (voice_we),
        .voice_sel  (voice_sel),
        .voice_note (voice_note),
        .voice_gate (voice_gate),
        .step_idx   (step_idx),
        .step_pulse (step_pulse),
        .busy       (busy)
    );

    // 50 MHz clock.
    always #10 clock = ~clock;

    // Synchronous pattern ROM: data valid one clock after the address.
    always @(posedge clock) rom_data <= rom_mem[rom_addr];

    // Record writes and step pulses away from the active edge.
    always @(negedge clock) begin
        if (voice_we) wr_q.push_back({voice_sel, voice_note, voice_gate});
        if (step_pulse) pulse_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic check_write(input string tag, input int idx, input logic [1:0] sel,
                               input logic [5:0] note, input logic gate);
        wr_t w;
        w = '1;
        if (idx < wr_q.size()) w = wr_q[idx];
        check(tag, 32'(w), 32'({sel, note, gate}));
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        sample_ena = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic strobe();
        sample_ena = 1'b1;
        cycle();
        sample_ena = 1'b0;
    endtask

    task automatic strobe_pair();
        strobe();
        idle(3);
        strobe();
        idle(40);
    endtask

    // Watchdog: the directed sequence is a few thousand cycles.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Row s, voice v: gate on, note 10+4s+v; row 1 voice 2 is tied.
        for (int s = 0; s < 32; s++) begin
            for (int v = 0; v < 4; v++) begin
                rom_mem[s * 4 + v] = {1'b1, 1'b0, 6'((s * 4 + v + 10) % 64)};
            end
        end
        rom_mem[6] = {1'b1, 1'b1, 6'd16};

        reset      = 1'b1;
        run        = 1'b0;
        sample_ena = 1'b0;
        tempo      = 12'd4;
        idle(3);

        // Reset state.
        check("reset voice_we", 32'(voice_we), 32'd0);
        check("reset voice_bus", 32'({voice_sel, voice_note, voice_gate}), 32'd0);
        check("reset step_idx", 32'(step_idx), 32'd0);
        check("reset step_pulse", 32'(step_pulse), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset rom_addr", 32'(rom_addr), 32'd0);

        reset = 1'b0;
        idle(2);
        check("idle busy", 32'(busy), 32'd0);

        // 1. First row plays at once; all four writes land within 12 clocks.
        wr_q.delete();
        run = 1'b1;
        repeat (13) cycle();
        check("row0 writes", 32'(wr_q.size()), 32'd4);
        for (int v = 0; v < 4; v++) check_write("row0 write", v, 2'(v), 6'(10 + v), 1'b1);
        check("row0 pulses", 32'(pulse_cnt), 32'd1);
        check("row0 step_idx", 32'(step_idx), 32'd0);
        check("row0 done busy", 32'(busy), 32'd0);

        // 2/3. tempo=4, strobes every 16 clocks: one step per 4 strobes, wrap 31->0;
        // row 1 has voice 2 tied.
        for (int s = 1; s <= 32; s++) begin
            repeat (3) begin
                idle(15);
                strobe();
            end
            idle(2);
            check("no early step", 32'(pulse_cnt), 32'(s));
            idle(13);
            wr_q.delete();
            strobe();
            check("step_idx", 32'(step_idx), 32'(s % 32));
            cycle();
            check("step pulse", 32'(pulse_cnt), 32'(s + 1));
            idle(14);
            if (s == 1) begin
                check("tie writes", 32'(wr_q.size()), 32'd3);
                check_write("tie write0", 0, 2'd0, 6'd14, 1'b1);
                check_write("tie write1", 1, 2'd1, 6'd15, 1'b1);
                check_write("tie write2", 2, 2'd3, 6'd17, 1'b1);
            end else begin
                check("row writes", 32'(wr_q.size()), 32'd4);
            end
        end
        check("wrapped step_idx", 32'(step_idx), 32'd0);

        // 4. tempo=0 then tempo=1: every strobe is a step, including strobes
        // that land mid-row and are held pending.
        tempo = 12'd0;
        repeat (3) begin
            idle(15);
            strobe();
        end
        idle(15);
        strobe();
        idle(20);
        check("tempo0 reload step", 32'(step_idx), 32'd1);
        check("tempo0 reload pulses", 32'(pulse_cnt), 32'd34);
        repeat (4) strobe_pair();
        check("tempo0 step_idx", 32'(step_idx), 32'd9);
        check("tempo0 pulses", 32'(pulse_cnt), 32'd42);
        check("tempo0 busy", 32'(busy), 32'd0);
        tempo = 12'd1;
        repeat (4) strobe_pair();
        check("tempo1 step_idx", 32'(step_idx), 32'd17);
        check("tempo1 pulses", 32'(pulse_cnt), 32'd50);

        // 5. run falls during the write of voice 1: row finishes, then release.
        wr_q.delete();
        strobe();
        repeat (5) cycle();
        check("stop in write v1 we", 32'(voice_we), 32'd1);
        check("stop in write v1 sel", 32'(voice_sel), 32'd1);
        run = 1'b0;
        idle(20);
        check("stop writes", 32'(wr_q.size()), 32'd8);
        for (int v = 0; v < 4; v++) check_write("stop row write", v, 2'(v), 6'(18 + v), 1'b1);
        for (int v = 0; v < 4; v++) check_write("release write", 4 + v, 2'(v), 6'd0, 1'b0);
        check("stop busy", 32'(busy), 32'd0);
        check("stop step_idx held", 32'(step_idx), 32'd18);
        check("stop pulses", 32'(pulse_cnt), 32'd51);

        // 6. Reset in the middle of a row, then restart from step 0.
        run = 1'b1;
        cycle();
        check("restart step_idx", 32'(step_idx), 32'd0);
        check("restart step_pulse", 32'(step_pulse), 32'd1);
        idle(14);
        wr_q.delete();
        strobe();
        repeat (3) cycle();
        check("pre-reset rom_addr", 32'(rom_addr), 32'd5);
        check("pre-reset busy", 32'(busy), 32'd1);
        check("pre-reset writes", 32'(wr_q.size()), 32'd1);
        reset = 1'b1;
        #1;
        check("mid-row reset rom_addr", 32'(rom_addr), 32'd0);
        check("mid-row reset busy", 32'(busy), 32'd0);
        check("mid-row reset step_idx", 32'(step_idx), 32'd0);
        check("mid-row reset we", 32'(voice_we), 32'd0);
        idle(4);
        check("no write in reset", 32'(wr_q.size()), 32'd1);
        reset = 1'b0;
        wr_q.delete();
        cycle();
        check("post-reset step_pulse", 32'(step_pulse), 32'd1);
        check("post-reset step_idx", 32'(step_idx), 32'd0);
        idle(13);
        check("post-reset writes", 32'(wr_q.size()), 32'd4);
        for (int v = 0; v < 4; v++) check_write("post-reset write", v, 2'(v), 6'(10 + v), 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
